// File: rtl/sse_pkg.sv
// Shared types for serial_shift_engine: sequencer states and shift modes.
package sse_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        SH_L  = 2'b00,
        SH_R  = 2'b01,
        ROT_L = 2'b10,
        ROT_R = 2'b11
    } mode_t;

endpackage

// File: rtl/step_counter.sv
// CW-bit step counter with synchronous clear, enable and a programmable
// terminal match that flags the step about to complete the run.
module step_counter #(
    parameter int CW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr_i,
    input  logic          en_i,
    input  logic [CW-1:0] amt_i,
    output logic [CW-1:0] cnt_o,
    output logic          term_o
);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o  = cnt_q;
    // High while the step in progress is the last one of the run.
    assign term_o = ((cnt_q + CW'(1)) == amt_i);

endmodule

// File: rtl/serial_shift_engine.sv
// Universal shift register with built-in shift-count sequencer and start/busy/done handshake.
// Build option: define SSE_ARITH_EN to make mode 01 an arithmetic right shift.
module serial_shift_engine
    import sse_pkg::*;
#(
    parameter int N  = 8,
    parameter int CW = $clog2(N) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ld,
    input  logic [N-1:0]  pin,
    input  logic          start,
    input  logic [1:0]    mode,
    input  logic [CW-1:0] amt,
    input  logic          sin,
    output logic [N-1:0]  qout,
    output logic          sout,
    output logic [CW-1:0] cnt,
    output logic          busy,
    output logic          done
);

    state_t        state_q, state_d;
    mode_t         mode_q, mode_d;
    logic [CW-1:0] amt_q, amt_d;
    logic [N-1:0]  q_q, q_d;
    logic [N-1:0]  shifted;
    logic          cnt_clr;
    logic          cnt_en;
    logic          cnt_term;

    step_counter #(.CW(CW)) u_step_counter (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (cnt_clr),
        .en_i   (cnt_en),
        .amt_i  (amt_q),
        .cnt_o  (cnt),
        .term_o (cnt_term)
    );

    always_comb begin
        shifted = q_q;
        case (mode_q)
            SH_L:  shifted = {q_q[N-2:0], sin};
`ifdef SSE_ARITH_EN
            SH_R:  shifted = {q_q[N-1], q_q[N-1:1]};
`else
            SH_R:  shifted = {sin, q_q[N-1:1]};
`endif
            ROT_L: shifted = {q_q[N-2:0], q_q[N-1]};
            ROT_R: shifted = {q_q[0], q_q[N-1:1]};
            default: shifted = q_q;
        endcase
    end

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        amt_d   = amt_q;
        q_d     = q_q;
        cnt_clr = 1'b0;
        cnt_en  = 1'b0;
        case (state_q)
            IDLE: begin
                // Load and start may coincide: the first shift then works on pin.
                if (ld) begin
                    q_d = pin;
                end
                if (start) begin
                    mode_d  = mode_t'(mode);
                    amt_d   = amt;
                    cnt_clr = 1'b1;
                    state_d = (amt == '0) ? DONE : SHIFT;
                end
            end
            SHIFT: begin
                q_d    = shifted;
                cnt_en = 1'b1;
                if (cnt_term) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            mode_q  <= SH_L;
            amt_q   <= '0;
            q_q     <= '0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            amt_q   <= amt_d;
            q_q     <= q_d;
        end
    end

    assign qout = q_q;
    // Left-going modes (00, 10) eject the MSB; right-going modes eject the LSB.
    assign sout = mode_q[0] ? q_q[0] : q_q[N-1];
    assign busy = (state_q == SHIFT);
    assign done = (state_q == DONE);

endmodule

// File: doc/serial_shift_engine.md
Name: serial_shift_engine

Overview:
Parametrised universal shift register with an on-board shift-count sequencer and a start/busy/done handshake.
- Supports logical shift and rotate in both directions.
- One parallel load, then a single start performs an exact programmed number of shifts.
- Replaces hand-built counter plus shift_register pairs in serial datapaths such as multipliers, dividers and serialisers.

Parameters:
N, 8, data width in bits (N >= 2)
CW, $clog2(N)+1, width of the amt and cnt fields (override permitted)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  reset, asynchronous, active-high
ld  in  1  parallel load of pin; honoured only in IDLE
pin  in  N  parallel load data
start  in  1  begin transfer; honoured only in IDLE
mode  in  2  00 shift left, 01 shift right, 10 rotate left, 11 rotate right; sampled on accepted start
amt  in  CW  number of shifts; sampled on accepted start
sin  in  1  serial fill bit for shift modes, sampled every shift cycle
qout  out  N  register contents
sout  out  1  bit leaving on the current shift: qout[N-1] if latched mode is left/rotl, else qout[0]
cnt  out  CW  shifts completed in the current transfer
busy  out  1  high in SHIFT state
done  out  1  one-cycle pulse after the last shift

Behaviour:
- Reset (async, active-high): qout=0, cnt=0, busy=0, done=0, state=IDLE, latched mode=00.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - ld=1 loads pin into qout at the next edge.
  - start=1 latches mode and amt and clears cnt.
  - If amt>0, next state is SHIFT. If amt=0, next state is DONE with qout untouched.
  - ld and start in the same cycle: pin is loaded and the transfer is accepted on the same edge; the first shift operates on pin.
- SHIFT:
  - One shift per clock; cnt increments each shift.
  - On the edge performing shift number amt, go to DONE.
  - busy is high for exactly amt cycles.
  - ld and start are ignored; mode, amt and pin changes have no effect.
- DONE:
  - done=1 for exactly one cycle, then IDLE unconditionally.
  - cnt holds its final value (=amt) until the next accepted start.
  - A start arriving in DONE is ignored; it is accepted on the following IDLE cycle.
- Shift semantics (N bits):
  - Left: {q[N-2:0], sin}.
  - Right: {sin, q[N-1:1]}.
  - Rotate left: {q[N-2:0], q[N-1]}.
  - Rotate right: {q[0], q[N-1:1]}.
- amt may exceed N:
  - Rotates wrap modulo N.
  - Shifts keep filling with sin.
  - No saturation; cnt never wraps because amt <= 2^CW-1.
- sout is combinational from qout and the latched mode, valid in every state.
- Reset asserted mid-transfer aborts immediately to reset values; no done pulse.
- Latency: start accepted at edge k; shifts at edges k+1..k+amt; done high in the cycle after edge k+amt.

Optional Feature:
Macro SSE_ARITH_EN.
- Defined: mode 01 is arithmetic right shift {q[N-1], q[N-1:1]}; sin is ignored for mode 01.
- Undefined: mode 01 is logical right shift with sin fill as above.
- All other modes are identical in both builds.

Decomposition:
- Package sse_pkg holds:
  - enum typedef for state (IDLE, SHIFT, DONE);
  - enum typedef for mode (SH_L=2'b00, SH_R=2'b01, ROT_L=2'b10, ROT_R=2'b11).
- One sub-module, step_counter:
  - CW-bit counter with synchronous clear, enable, and terminal-match output (cnt+1 == amt);
  - used as the shift sequencer;
  - generalises the team counter with a programmable terminal value.

Test Plan:
- N=8: ld pin=8'hA5, start amt=3, mode=00, sin=1 -> busy 3 cycles; sout 1,0,1; qout 4B,97,2F; done one cycle; cnt=3.
- mode=11, pin=8'h81: amt=1 -> qout=C0. Repeat with amt=8 -> qout=81 and busy exactly 8 cycles.
- start with amt=0 -> busy never high; done pulse next cycle; qout unchanged.
- During SHIFT (amt=5) drive start=1 and ld=1 with pin=8'hFF -> both ignored; transfer completes normally; no second done.
- Assert rst at 2nd shift cycle -> qout, cnt, busy, done all 0 immediately (before the next edge); IDLE after release.
- pin=8'h90, mode=01, amt=2, sin=0 -> qout=E4 with SSE_ARITH_EN, qout=24 without.
